// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array tile sequencer:
// FSM state encoding, default geometry and drain length.
package sa_ctrl_pkg;

    localparam int SA_WIDTH_DEF   = 4;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 8;
    localparam int DRAIN_CYCLES   = 2 * SA_WIDTH_DEF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } sa_state_t;

    // Drain length for an arbitrary array width, so the top can be re-parameterised.
    function automatic int drain_cycles(input int sa_width);
        return 2 * sa_width;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// 1-bit delay line with DEPTH taps; tap k is the input delayed by 1+k cycles.
module sa_skew_line #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [DEPTH-1:0] taps
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

endmodule

// File: rtl/sa_controller.sv
// Tile sequencer for the weight-stationary systolic array: loads weights,
// streams ifmap vectors with per-row/column enable skew, drains, then pulses done.
module sa_controller
    import sa_ctrl_pkg::*;
#(
    parameter int SA_WIDTH   = SA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  num_vec_i,
    input  logic [ADDR_WIDTH-1:0] w_base_i,
    input  logic [ADDR_WIDTH-1:0] i_base_i,
    output logic                  wbuf_rd_en_o,
    output logic [ADDR_WIDTH-1:0] wbuf_addr_o,
    output logic                  ibuf_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ibuf_addr_o,
    output logic [SA_WIDTH-1:0]   weight_en_o,
    output logic [SA_WIDTH-1:0]   ifmap_en_o,
    output logic [SA_WIDTH-1:0]   psum_en_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [CNT_WIDTH-1:0] LOAD_LAST  = CNT_WIDTH'(SA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(drain_cycles(SA_WIDTH) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    sa_state_t             state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  num_vec_q;
    logic [ADDR_WIDTH-1:0] w_base_q;
    logic [ADDR_WIDTH-1:0] i_base_q;
    logic                  wbuf_rd_q;

    // One counter is reused by every phase; FEED stops at num_vec-1 so 2^CNT_WIDTH-1 never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            num_vec_q <= '0;
            w_base_q  <= '0;
            i_base_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        num_vec_q <= num_vec_i;
                        w_base_q  <= w_base_i;
                        i_base_q  <= i_base_i;
                        cnt       <= '0;
                        state     <= ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (cnt == LOAD_LAST) begin
                        cnt   <= '0;
                        state <= (num_vec_q != '0) ? ST_FEED : ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_FEED: begin
                    if (cnt == num_vec_q - CNT_ONE) begin
                        cnt   <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbuf_rd_en_o = (state == ST_LOAD_W);
    assign ibuf_rd_en_o = (state == ST_FEED);
    assign wbuf_addr_o  = wbuf_rd_en_o ? w_base_q + ADDR_WIDTH'(cnt) : '0;
    assign ibuf_addr_o  = ibuf_rd_en_o ? i_base_q + ADDR_WIDTH'(cnt) : '0;
    assign busy_o       = (state != ST_IDLE);
    assign done_o       = (state == ST_DONE);

    // Weight enable lines up with the buffer's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_rd_q <= 1'b0;
        end else begin
            wbuf_rd_q <= wbuf_rd_en_o;
        end
    end

    assign weight_en_o = {SA_WIDTH{wbuf_rd_q}};

    sa_skew_line #(.DEPTH(SA_WIDTH)) u_ifmap_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ibuf_rd_en_o),
        .taps  (ifmap_en_o)
    );

    sa_skew_line #(.DEPTH(SA_WIDTH)) u_psum_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ibuf_rd_en_o),
        .taps  (psum_en_o)
    );

endmodule

// File: tb/tb_sa_controller.sv
// Scoreboard bench for sa_controller: stimulus pushes expected reads, done pulses
// and per-cycle enable patterns; a negedge monitor compares whatever the DUT presents.
module tb_sa_controller;

    localparam int SA  = 4;
    localparam int MAXC = 4000;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
    } rd_exp_t;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic [7:0] num_vec_i;
    logic [7:0] w_base_i;
    logic [7:0] i_base_i;
    logic       wbuf_rd_en_o;
    logic [7:0] wbuf_addr_o;
    logic       ibuf_rd_en_o;
    logic [7:0] ibuf_addr_o;
    logic [3:0] weight_en_o;
    logic [3:0] ifmap_en_o;
    logic [3:0] psum_en_o;
    logic       busy_o;
    logic       done_o;

    int check_count = 0;
    int error_count = 0;
    int gcyc = 0;

    rd_exp_t wq[$];
    rd_exp_t iq[$];
    int      dq[$];
    logic [3:0] exp_wen  [0:MAXC-1];
    logic [3:0] exp_ien  [0:MAXC-1];
    logic       exp_busy [0:MAXC-1];

    sa_controller #(.SA_WIDTH(4), .ADDR_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .num_vec_i    (num_vec_i),
        .w_base_i     (w_base_i),
        .i_base_i     (i_base_i),
        .wbuf_rd_en_o (wbuf_rd_en_o),
        .wbuf_addr_o  (wbuf_addr_o),
        .ibuf_rd_en_o (ibuf_rd_en_o),
        .ibuf_addr_o  (ibuf_addr_o),
        .weight_en_o  (weight_en_o),
        .ifmap_en_o   (ifmap_en_o),
        .psum_en_o    (psum_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) gcyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, gcyc, act, exp);
        end
    endtask

    // Expected behaviour of one tile whose start is sampled at the end of cycle t0.
    function automatic void pushExpect(input int t0, input logic [7:0] wb, input logic [7:0] ib, input int n);
        int   done_cyc;
        logic [7:0] a;
        done_cyc = (n == 0) ? t0 + SA + 1 : t0 + 3*SA + n + 1;
        for (int k = 0; k < SA; k++) begin
            a = wb + 8'(k);
            wq.push_back('{cyc: t0 + 1 + k, addr: a});
            exp_wen[t0 + 2 + k] = 4'hF;
        end
        for (int j = 0; j < n; j++) begin
            a = ib + 8'(j);
            iq.push_back('{cyc: t0 + SA + 1 + j, addr: a});
            for (int r = 0; r < SA; r++) begin
                exp_ien[t0 + SA + 2 + j + r][r] = 1'b1;
            end
        end
        for (int c = t0 + 1; c <= done_cyc; c++) exp_busy[c] = 1'b1;
        dq.push_back(done_cyc);
    endfunction

    function automatic void clearExpect(input int from);
        wq.delete();
        iq.delete();
        dq.delete();
        for (int c = from; c < MAXC; c++) begin
            exp_wen[c]  = 4'h0;
            exp_ien[c]  = 4'h0;
            exp_busy[c] = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input logic [7:0] wb, input logic [7:0] ib, input int n, output int t0);
        @(negedge clk);
        start_i   = 1'b1;
        num_vec_i = 8'(n);
        w_base_i  = wb;
        i_base_i  = ib;
        t0 = gcyc;
        pushExpect(t0, wb, ib, n);
        @(negedge clk);
        start_i   = 1'b0;
        num_vec_i = 8'hAA;
        w_base_i  = 8'h55;
        i_base_i  = 8'h33;
    endtask

    task automatic waitTileEnd();
        int budget;
        budget = 0;
        while ((wq.size() != 0 || iq.size() != 0 || dq.size() != 0 || busy_o) && budget < 600) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("tile_completes_in_budget", 32'(budget < 600), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: per-cycle enable comparisons plus scoreboard pops on every strobe.
    always @(negedge clk) begin
        rd_exp_t e;
        int      dc;
        checkOutput("weight_en", 32'(weight_en_o), 32'(exp_wen[gcyc]));
        checkOutput("ifmap_en",  32'(ifmap_en_o),  32'(exp_ien[gcyc]));
        checkOutput("psum_en",   32'(psum_en_o),   32'(exp_ien[gcyc]));
        checkOutput("busy",      32'(busy_o),      32'(exp_busy[gcyc]));
        if (wbuf_rd_en_o) begin
            if (wq.size() == 0) checkOutput("wbuf_rd_unexpected", 32'd1, 32'd0);
            else begin
                e = wq.pop_front();
                checkOutput("wbuf_rd_cycle", 32'(gcyc), 32'(e.cyc));
                checkOutput("wbuf_addr", 32'(wbuf_addr_o), 32'(e.addr));
            end
        end else if (wq.size() != 0 && wq[0].cyc <= gcyc) begin
            e = wq.pop_front();
            checkOutput("wbuf_rd_missing", 32'd0, 32'd1);
        end
        if (ibuf_rd_en_o) begin
            if (iq.size() == 0) checkOutput("ibuf_rd_unexpected", 32'd1, 32'd0);
            else begin
                e = iq.pop_front();
                checkOutput("ibuf_rd_cycle", 32'(gcyc), 32'(e.cyc));
                checkOutput("ibuf_addr", 32'(ibuf_addr_o), 32'(e.addr));
            end
        end else if (iq.size() != 0 && iq[0].cyc <= gcyc) begin
            e = iq.pop_front();
            checkOutput("ibuf_rd_missing", 32'd0, 32'd1);
        end
        if (done_o) begin
            if (dq.size() == 0) checkOutput("done_unexpected", 32'd1, 32'd0);
            else begin
                dc = dq.pop_front();
                checkOutput("done_cycle", 32'(gcyc), 32'(dc));
            end
        end else if (dq.size() != 0 && dq[0] <= gcyc) begin
            dc = dq.pop_front();
            checkOutput("done_missing", 32'd0, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        for (int c = 0; c < MAXC; c++) begin
            exp_wen[c]  = 4'h0;
            exp_ien[c]  = 4'h0;
            exp_busy[c] = 1'b0;
        end
        rst_n     = 1'b0;
        start_i   = 1'b0;
        num_vec_i = 8'h00;
        w_base_i  = 8'h00;
        i_base_i  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
            {wbuf_rd_en_o, ibuf_rd_en_o, busy_o, done_o, weight_en_o, ifmap_en_o, psum_en_o, wbuf_addr_o, ibuf_addr_o},
            32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic tile N=3");
        applyStimulus(8'h10, 8'h40, 3, t0);
        waitTileEnd();

        $display("[TB] zero vectors");
        applyStimulus(8'h20, 8'h50, 0, t0);
        waitTileEnd();

        $display("[TB] start while busy is ignored");
        applyStimulus(8'h10, 8'h40, 3, t0);
        repeat (6) @(negedge clk);
        start_i   = 1'b1;
        num_vec_i = 8'd9;
        i_base_i  = 8'h80;
        @(negedge clk);
        start_i = 1'b0;
        waitTileEnd();

        $display("[TB] back-to-back with start held");
        @(negedge clk);
        start_i   = 1'b1;
        num_vec_i = 8'd2;
        w_base_i  = 8'h30;
        i_base_i  = 8'h70;
        t0 = gcyc;
        pushExpect(t0, 8'h30, 8'h70, 2);
        pushExpect(t0 + 3*SA + 2 + 1 + 1, 8'h30, 8'h70, 2);
        repeat (20) @(negedge clk);
        start_i = 1'b0;
        waitTileEnd();

        $display("[TB] ifmap address wrap");
        applyStimulus(8'hF0, 8'hFE, 4, t0);
        waitTileEnd();

        $display("[TB] maximum vector count");
        applyStimulus(8'h00, 8'h00, 255, t0);
        waitTileEnd();

        $display("[TB] reset mid-feed");
        applyStimulus(8'h08, 8'h60, 5, t0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_feeding", 32'(ibuf_rd_en_o), 32'd1);
        rst_n = 1'b0;
        clearExpect(gcyc);
        #1;
        checkOutput("reset_midtile_outputs",
            {wbuf_rd_en_o, ibuf_rd_en_o, busy_o, done_o, weight_en_o, ifmap_en_o, psum_en_o, wbuf_addr_o, ibuf_addr_o},
            32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        checkOutput("scoreboard_empty", 32'(wq.size() + iq.size() + dq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
